// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op and FSM state encodings for the multiply/divide unit
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_RUN  = 2'b10,
        ST_FIX  = 2'b11
    } state_e;

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module mdu_step
    import mdu_pkg::*;
#(
    parameter int DW = 32
) (
    input  op_e             op,
    input  logic [2*DW-1:0] acc,
    input  logic [DW-1:0]   operand,
    output logic [2*DW-1:0] acc_next
);

    logic [DW:0] sum;
    logic [DW:0] shifted;
    logic [DW:0] diff;

    // MUL: acc = {partial product, remaining multiplier bits}.
    // DIV: acc = {partial remainder, dividend bits shifting into quotient}.
    always_comb begin
        sum      = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, operand} : '0);
        shifted  = acc[2*DW-1:DW-1];
        diff     = shifted - {1'b0, operand};
        acc_next = acc;
        if (op == OP_MUL) begin
            acc_next = {sum, acc[DW-1:1]};
        end else if (!diff[DW]) begin
            acc_next = {diff[DW-1:0], acc[DW-2:0], 1'b1};
        end else begin
            acc_next = {shifted[DW-1:0], acc[DW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic          Sign,
    input  logic [1:0]    op,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] HI,
    output logic [DW-1:0] LO
);

    localparam int CW = $clog2(DW);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d, opnd_q, opnd_d;
    logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*DW-1:0] acc_q, acc_d, acc_step;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic            dz_q, dz_d, done_q, done_d;

    logic            sa, sb;
    logic [DW-1:0]   mag_a, mag_b, quo, rem;
    logic [2*DW-1:0] prod;

    mdu_step #(.DW(DW)) u_step (
        .op       (op_q),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (acc_step)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        sa       = sign_q & a_q[DW-1];
        sb       = sign_q & b_q[DW-1];
        mag_a    = sa ? -a_q : a_q;
        mag_b    = sb ? -b_q : b_q;
        prod     = neg_lo_q ? -acc_q : acc_q;
        quo      = neg_lo_q ? -acc_q[DW-1:0] : acc_q[DW-1:0];
        rem      = neg_hi_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_e'(op))
                        OP_MUL, OP_DIV: begin
                            a_d     = A;
                            b_d     = B;
                            sign_d  = Sign;
                            op_d    = op_e'(op);
                            state_d = ST_PREP;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                    endcase
                end
            end
            ST_PREP: begin
                // Low half seeds the multiplier or dividend; high half starts cleared.
                if (op_q == OP_MUL) begin
                    acc_d    = {{DW{1'b0}}, mag_b};
                    opnd_d   = mag_a;
                    neg_hi_d = sa ^ sb;
                end else begin
                    acc_d    = {{DW{1'b0}}, mag_a};
                    opnd_d   = mag_b;
                    neg_hi_d = sa;
                end
                neg_lo_d = sa ^ sb;
                dz_d     = (op_q == OP_DIV) && (b_q == '0);
                cnt_d    = '0;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (dz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else if (op_q == OP_MUL) begin
                    hi_d = prod[2*DW-1:DW];
                    lo_d = prod[DW-1:0];
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
